wbuff_bank_dbuf: RTL and testbench

- Next-generation weight buffer bank: on-chip weight SRAM plus a load sequencer that reads a run of weights into a shadow tap-register set, then swaps it atomically into the active set that feeds the PE row.
- The shadow/active double buffer lets the next kernel row load while the current one computes.
- Adds per-tap zero mask, nonzero count and address wrap-around.
- Sits between the global weight loader and one PE row; the raw read data also feeds the last PE row.

---
 rtl/wbuff_bank_dbuf.sv | 193 +++++++++++++++++++
 tb/tb_wbuff_bank_dbuf.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbuff_bank_dbuf.sv
// Weight buffer bank: weight SRAM, a load sequencer that fills a shadow tap set,
// and an atomic shadow-to-active swap that feeds one PE row.
module wbuff_bank_dbuf #(
    parameter int NB_TAPS      = 11,
    parameter int WEIGHT_WIDTH = 16,
    parameter int BUFFER_DEPTH = 72,
    parameter int ADDR_WIDTH   = $clog2(BUFFER_DEPTH),
    parameter int CNT_WIDTH    = $clog2(NB_TAPS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [WEIGHT_WIDTH-1:0]         wr_data,
    input  logic                            load_start,
    input  logic [ADDR_WIDTH-1:0]           load_base_addr,
    input  logic [CNT_WIDTH-1:0]            load_num_taps,
    input  logic                            swap,
    input  logic                            clear_all_wregs,
    input  logic                            byp_rd_en,
    input  logic [ADDR_WIDTH-1:0]           byp_rd_addr,
    output logic                            load_busy,
    output logic                            load_done,
    output logic                            swap_pending,
    output logic [NB_TAPS*WEIGHT_WIDTH-1:0] wregs,
    output logic [NB_TAPS-1:0]              wnz_mask,
    output logic [CNT_WIDTH-1:0]            wnz_count,
    output logic [WEIGHT_WIDTH-1:0]         last_pe_row_data_in
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(BUFFER_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  TAPS_MAX  = CNT_WIDTH'(NB_TAPS);

    typedef logic [NB_TAPS-1:0][WEIGHT_WIDTH-1:0] taps_t;

    logic [WEIGHT_WIDTH-1:0] mem [BUFFER_DEPTH];

    logic [1:0]              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    k_q, k_d;
    logic [CNT_WIDTH-1:0]    n_q, n_d;
    logic [CNT_WIDTH-1:0]    cap_idx_q, cap_idx_d;
    logic                    cap_vld_q, cap_vld_d;
    logic                    done_q, done_d;
    logic                    pend_q, pend_d;
    taps_t                   shadow_q, shadow_d;
    taps_t                   active_q, active_d;
    logic [NB_TAPS-1:0]      mask_q, mask_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [WEIGHT_WIDTH-1:0] rd_data_q;

    logic                    idle;
    logic                    seq_rd;
    logic                    rd_en;
    logic                    do_swap;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [CNT_WIDTH-1:0]    n_start;

    function automatic logic [CNT_WIDTH-1:0] sat_taps(input logic [CNT_WIDTH-1:0] req);
        return (req > TAPS_MAX) ? TAPS_MAX : req;
    endfunction

    function automatic logic [NB_TAPS-1:0] nz_mask(input taps_t t);
        logic [NB_TAPS-1:0] m;
        for (int i = 0; i < NB_TAPS; i++) m[i] = |t[i];
        return m;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NB_TAPS-1:0] m);
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < NB_TAPS; i++) c = c + CNT_WIDTH'(m[i]);
        return c;
    endfunction

    assign idle    = (state_q == S_IDLE);
    assign seq_rd  = (state_q == S_READ);
    // A clear cycle issues no read so the PE-row data register keeps its value.
    assign rd_en   = !clear_all_wregs && (seq_rd || (idle && !load_start && byp_rd_en));
    assign rd_addr = seq_rd ? addr_q : byp_rd_addr;
    assign do_swap = idle && (swap || pend_q);
    assign n_start = sat_taps(load_num_taps);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read stage: old data wins on a same-address read/write collision.
    always_ff @(posedge clk) begin
        if (rst)        rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem[rd_addr];
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        k_d       = k_q;
        n_d       = n_q;
        cap_vld_d = 1'b0;
        cap_idx_d = cap_idx_q;
        done_d    = 1'b0;
        pend_d    = !idle && (pend_q || swap);
        shadow_d  = shadow_q;
        active_d  = active_q;
        mask_d    = mask_q;
        count_d   = count_q;

        if (cap_vld_q) shadow_d[cap_idx_q] = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    addr_d   = load_base_addr;
                    k_d      = '0;
                    n_d      = n_start;
                    shadow_d = '0;
                    state_d  = (n_start == '0) ? S_LAST : S_READ;
                end
            end
            S_READ: begin
                cap_vld_d = 1'b1;
                cap_idx_d = k_q;
                addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                k_d       = k_q + 1'b1;
                if (k_q == n_q - 1'b1) state_d = S_LAST;
            end
            S_LAST: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Swap copies the pre-edge shadow, so a same-edge load_start cannot corrupt it.
        if (do_swap) begin
            active_d = shadow_q;
            mask_d   = nz_mask(shadow_q);
            count_d  = popcount(nz_mask(shadow_q));
        end

        if (clear_all_wregs) begin
            state_d   = S_IDLE;
            cap_vld_d = 1'b0;
            done_d    = 1'b0;
            pend_d    = 1'b0;
            shadow_d  = '0;
            active_d  = '0;
            mask_d    = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cap_vld_q <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            mask_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cap_vld_q <= cap_vld_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        k_q       <= k_d;
        n_q       <= n_d;
        cap_idx_q <= cap_idx_d;
    end

    assign load_busy           = !idle;
    assign load_done           = done_q;
    assign swap_pending        = pend_q;
    assign wregs               = active_q;
    assign wnz_mask            = mask_q;
    assign wnz_count           = count_q;
    assign last_pe_row_data_in = rd_data_q;

endmodule

// File: tb/tb_wbuff_bank_dbuf.sv
// Bench for wbuff_bank_dbuf: directed scenarios plus random traffic, checked every
// cycle against a cycle-indexed model of the load/swap rules.
module tb_wbuff_bank_dbuf;
    localparam int NB = 11;
    localparam int W  = 16;
    localparam int D  = 72;
    localparam int AW = 7;
    localparam int CW = 4;
    localparam int WV = NB * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base_addr = '0;
    logic [CW-1:0] load_num_taps = '0;
    logic          swap = 1'b0;
    logic          clear_all_wregs = 1'b0;
    logic          byp_rd_en = 1'b0;
    logic [AW-1:0] byp_rd_addr = '0;
    logic          load_busy, load_done, swap_pending;
    logic [WV-1:0] wregs;
    logic [NB-1:0] wnz_mask;
    logic [CW-1:0] wnz_count;
    logic [W-1:0]  last_pe_row_data_in;

    always #5 clk = ~clk;

    wbuff_bank_dbuf dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_start(load_start), .load_base_addr(load_base_addr), .load_num_taps(load_num_taps),
        .swap(swap), .clear_all_wregs(clear_all_wregs),
        .byp_rd_en(byp_rd_en), .byp_rd_addr(byp_rd_addr),
        .load_busy(load_busy), .load_done(load_done), .swap_pending(swap_pending),
        .wregs(wregs), .wnz_mask(wnz_mask), .wnz_count(wnz_count),
        .last_pe_row_data_in(last_pe_row_data_in)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // Model: a load started in cycle T with n taps is busy over T+1..T+n+1,
    // reads (base+k) mod D in T+1+k, fills shadow[k] at the end of T+2+k, done in T+n+2.
    logic [W-1:0] mem_m [D];
    logic [W-1:0] shd_m [NB];
    logic [W-1:0] act_m [NB];
    logic [W-1:0] rd_m = '0;
    bit pend_m = 0, done_m = 0, ld_act = 0;
    int ld_t = 0, ld_base = 0, ld_n = 0;
    bit m_busy;
    logic [W-1:0] m_old_rd;
    int m_c;

    function automatic bit busy_at(input int c);
        return ld_act && (c >= ld_t + 1) && (c <= ld_t + ld_n + 1);
    endfunction

    task automatic check(input string nm, input logic [WV-1:0] act, input logic [WV-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        m_c = cyc;
        if (rst) begin
            foreach (shd_m[i]) begin shd_m[i] = '0; act_m[i] = '0; end
            rd_m = '0; pend_m = 0; done_m = 0; ld_act = 0;
        end else begin
            m_busy = busy_at(m_c);
            if (clear_all_wregs) begin
                foreach (shd_m[i]) begin shd_m[i] = '0; act_m[i] = '0; end
                pend_m = 0; done_m = 0; ld_act = 0;
            end else begin
                m_old_rd = rd_m;
                done_m = m_busy && (m_c == ld_t + ld_n + 1);
                if (m_busy && m_c >= ld_t + 1 && m_c <= ld_t + ld_n)
                    rd_m = mem_m[(ld_base + m_c - ld_t - 1) % D];
                else if (!m_busy && !load_start && byp_rd_en)
                    rd_m = mem_m[byp_rd_addr];
                if (m_busy && m_c >= ld_t + 2 && m_c <= ld_t + ld_n + 1)
                    shd_m[m_c - ld_t - 2] = m_old_rd;
                if (!m_busy && (swap || pend_m)) begin
                    act_m = shd_m;
                    pend_m = 0;
                end else if (m_busy && swap) begin
                    pend_m = 1;
                end
                if (!m_busy && load_start) begin
                    ld_act = 1; ld_t = m_c; ld_base = int'(load_base_addr);
                    ld_n = (int'(load_num_taps) > NB) ? NB : int'(load_num_taps);
                    foreach (shd_m[i]) shd_m[i] = '0;
                end
            end
        end
        if (wr_en) mem_m[wr_addr] = wr_data;
        cyc = m_c + 1;
    end

    logic [WV-1:0] exp_w;
    logic [NB-1:0] exp_m;
    int            exp_c;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_c = 0;
            for (int t = 0; t < NB; t++) begin
                exp_w[t*W +: W] = act_m[t];
                exp_m[t] = (act_m[t] != '0);
                exp_c += (act_m[t] != '0) ? 1 : 0;
            end
            check("load_busy", WV'(load_busy), WV'(busy_at(cyc)));
            check("load_done", WV'(load_done), WV'(done_m));
            check("swap_pending", WV'(swap_pending), WV'(pend_m));
            check("wregs", wregs, exp_w);
            check("wnz_mask", WV'(wnz_mask), WV'(exp_m));
            check("wnz_count", WV'(wnz_count), WV'(exp_c));
            check("rd_data", WV'(last_pe_row_data_in), WV'(rd_m));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = W'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_load(input int base, input int n, output int t);
        load_start = 1'b1; load_base_addr = AW'(base); load_num_taps = CW'(n);
        t = cyc;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (load_done) begin dc = cyc; break; end
        end
        if (dc < 0) check("done_timeout", WV'(0), WV'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int t0, dc, seen;
    logic [WV-1:0] lit, lit2;

    initial begin
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        check("rst_busy", WV'(load_busy), WV'(0));
        check("rst_wregs", wregs, WV'(0));
        check("rst_rd", WV'(last_pe_row_data_in), WV'(0));
        tick();
        rst = 1'b0;

        for (int a = 0; a < D; a++) wr(a, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom));

        // Plain 11-tap load.
        for (int a = 0; a <= 10; a++) wr(a, a + 1);
        start_load(0, 11, t0);
        wait_done(dc);
        check("t1_done_cycle", WV'(dc), WV'(t0 + 13));
        tick();
        pulse_swap();
        @(negedge clk);
        for (int t = 0; t < NB; t++) lit[t*W +: W] = W'(t + 1);
        check("t1_wregs", wregs, lit);
        check("t1_mask", WV'(wnz_mask), WV'(11'h7FF));
        check("t1_count", WV'(wnz_count), WV'(11));

        // Wrap-around load.
        wr(70, 5); wr(71, 0); wr(0, 7); wr(1, 9);
        start_load(70, 4, t0);
        wait_done(dc);
        check("t2_done_cycle", WV'(dc), WV'(t0 + 6));
        tick();
        pulse_swap();
        @(negedge clk);
        lit2 = '0;
        lit2[0*W +: W] = 16'd5; lit2[2*W +: W] = 16'd7; lit2[3*W +: W] = 16'd9;
        check("t2_wregs", wregs, lit2);
        check("t2_mask", WV'(wnz_mask), WV'(11'b1101));
        check("t2_count", WV'(wnz_count), WV'(3));

        // Swap requested during a load waits for load_done.
        for (int k = 0; k < 11; k++) wr(20 + k, 16'h100 + k);
        start_load(20, 11, t0);
        tick();
        pulse_swap();
        @(negedge clk);
        check("t3_pending", WV'(swap_pending), WV'(1));
        check("t3_active_held", wregs, lit2);
        wait_done(dc);
        check("t3_pending_at_done", WV'(swap_pending), WV'(1));
        check("t3_active_at_done", wregs, lit2);
        @(negedge clk);
        for (int t = 0; t < NB; t++) lit[t*W +: W] = W'(16'h100 + t);
        check("t3_pending_cleared", WV'(swap_pending), WV'(0));
        check("t3_wregs", wregs, lit);

        // Clear aborts a load.
        tick();
        for (int k = 0; k < 11; k++) wr(40 + k, 16'h400 + k);
        start_load(40, 11, t0);
        repeat (4) tick();
        clear_all_wregs = 1'b1;
        tick();
        clear_all_wregs = 1'b0;
        @(negedge clk);
        check("t4_busy", WV'(load_busy), WV'(0));
        check("t4_wregs", wregs, WV'(0));
        check("t4_count", WV'(wnz_count), WV'(0));
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (load_done) seen++;
        end
        check("t4_no_done", WV'(seen), WV'(0));
        tick();
        pulse_swap();
        @(negedge clk);
        check("t4_wregs_after_swap", wregs, WV'(0));

        // Read-during-write returns old data; bypass ignored while busy.
        tick();
        wr(3, 16'h1111);
        wr_en = 1'b1; wr_addr = 7'd3; wr_data = 16'hABCD;
        byp_rd_en = 1'b1; byp_rd_addr = 7'd3;
        tick();
        wr_en = 1'b0; byp_rd_en = 1'b0;
        @(negedge clk);
        check("t5_old_data", WV'(last_pe_row_data_in), WV'(16'h1111));
        tick();
        byp_rd_en = 1'b1;
        tick();
        byp_rd_en = 1'b0;
        @(negedge clk);
        check("t5_new_data", WV'(last_pe_row_data_in), WV'(16'hABCD));
        tick();
        wr(60, 16'h600); wr(61, 16'h601); wr(62, 16'h602);
        byp_rd_en = 1'b1; byp_rd_addr = 7'd3;
        start_load(60, 3, t0);
        tick();
        @(negedge clk);
        check("t5_busy_rd0", WV'(last_pe_row_data_in), WV'(16'h600));
        tick();
        @(negedge clk);
        check("t5_busy_rd1", WV'(last_pe_row_data_in), WV'(16'h601));
        byp_rd_en = 1'b0;
        wait_done(dc);
        check("t5_done_cycle", WV'(dc), WV'(t0 + 5));

        // Zero taps, oversized tap count, load_start while busy, reset mid-load.
        tick();
        start_load(10, 0, t0);
        @(negedge clk);
        check("t6_n0_busy", WV'(load_busy), WV'(1));
        wait_done(dc);
        check("t6_n0_done_cycle", WV'(dc), WV'(t0 + 2));
        tick();
        pulse_swap();
        @(negedge clk);
        check("t6_n0_wregs", wregs, WV'(0));
        tick();
        start_load(0, 15, t0);
        tick();
        load_start = 1'b1; load_base_addr = 7'd50; load_num_taps = 4'd2;
        tick();
        load_start = 1'b0;
        wait_done(dc);
        check("t6_n15_done_cycle", WV'(dc), WV'(t0 + 13));
        tick();
        pulse_swap();
        @(negedge clk);
        for (int t = 0; t < NB; t++) lit[t*W +: W] = W'(t + 1);
        lit[0*W +: W] = 16'd7; lit[1*W +: W] = 16'd9; lit[3*W +: W] = 16'hABCD;
        check("t6_n15_wregs", wregs, lit);
        tick();
        start_load(5, 11, t0);
        pulse_swap();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", WV'(load_busy), WV'(0));
        check("t6_rst_pending", WV'(swap_pending), WV'(0));
        check("t6_rst_wregs", wregs, WV'(0));
        check("t6_rst_rd", WV'(last_pe_row_data_in), WV'(0));

        // Random traffic.
        tick();
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 249) == 0);
            wr_en           = !rst && ($urandom_range(0, 9) < 3);
            wr_addr         = AW'($urandom_range(0, D - 1));
            wr_data         = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            load_start      = ($urandom_range(0, 11) == 0);
            load_base_addr  = AW'($urandom_range(0, D - 1));
            load_num_taps   = CW'($urandom_range(0, 15));
            swap            = ($urandom_range(0, 9) == 0);
            clear_all_wregs = ($urandom_range(0, 59) == 0);
            byp_rd_en       = ($urandom_range(0, 9) < 3);
            byp_rd_addr     = AW'($urandom_range(0, D - 1));
            tick();
        end
        rst = 1'b0; wr_en = 1'b0; load_start = 1'b0; swap = 1'b0;
        clear_all_wregs = 1'b0; byp_rd_en = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
